part_2_target_fringe: RTL and testbench
=======================================

# part_2_target_fringe

Target-side partition fringe for the two-partition co-simulation flow, and the counterpart of the initiator fringe. It collects the three exported vectors (slots 0..2, each `{wen, data}`) from the transport and applies them to the local partition on each mission-clock rising edge. It returns the local `{valid, o_data}` reply vector and holds `freeze_clk` while the exchange is incomplete.

## Interface

- `N`, 9: vector width, `{1-bit strobe, 8-bit data}`; only 9 is supported.
- `WATCHDOG_MAX`, 10000: `clk_i` cycles allowed in WAIT_VEC before error.
- `clk_i`  in  1  utility clock; all logic is on its rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `clk_0_h`  in  1  mission clock 0, sampled as data on `clk_i`.
- `freeze_clk`  out  1  holds the local mission clock generator.
- `rx_vld`  in  1  transport vector valid.
- `rx_idx`  in  2  slot index of `rx_vec`.
- `rx_vec`  in  N  received vector.
- `rx_rdy`  out  1  vector accepted when `rx_vld & rx_rdy`.
- `tx_vld`  out  1  reply vector valid.
- `tx_vec`  out  N  reply vector, `{valid_i, o_data_i}`.
- `tx_rdy`  in  1  reply accepted when `tx_vld & tx_rdy`.
- `valid_i`  in  1  local partition output.
- `o_data_i`  in  8  local partition output.
- `wen0_o`, `wen1_o`, `wen2_o`  out  1 each  applied strobes.
- `i_data0_o`, `i_data1_o`, `i_data2_o`  out  8 each  applied data.
- `wd_err`  out  1  sticky watchdog error.
- `ovr_err`  out  1  sticky error: mission edge seen outside IDLE.

## Operation

- Edge detect:
  - `clk_0_h_d <= clk_0_h`.
  - `edge_q <= clk_0_h & ~clk_0_h_d`.
- Staging: three 9-bit registers `stg[0..2]` plus a 3-bit mask `rcv_mask`.
- An accepted vector with `rx_idx` 0..2 writes `stg[rx_idx]` and sets `rcv_mask[rx_idx]`. A duplicate slot overwrites and the mask is unchanged.
- `rx_idx == 3` is accepted and discarded; it sets no mask bit.
- `rx_rdy = rst_n_i & (state==IDLE | state==WAIT_VEC) & (rcv_mask != 3'b111)`. Early vectors that arrive in IDLE are therefore buffered.
- FSM states: IDLE, WAIT_VEC, SEND, ERROR.
  - IDLE:
    - On `edge_q`, capture `{valid_i, o_data_i}` into `tx_vec` and go to WAIT_VEC.
  - WAIT_VEC:
    - When the registered `rcv_mask == 3'b111`, apply to outputs: `{wen0_o,i_data0_o} <= stg[0]`, and likewise for slots 1 and 2.
    - In the same cycle, clear `rcv_mask`, set `tx_vld`, and go to SEND.
    - Otherwise increment the watchdog. When it exceeds `WATCHDOG_MAX`, go to ERROR.
  - SEND:
    - On `tx_vld & tx_rdy`, clear `tx_vld` and go to IDLE.
  - ERROR:
    - Terminal until reset. `wd_err = 1`, `rx_rdy = 0`, `freeze_clk = 1`.
- `freeze_clk = (state != IDLE)`, decoded combinationally from the state register.
- The watchdog clears on every entry to WAIT_VEC.
- An `edge_q` pulse in WAIT_VEC, SEND or ERROR is ignored and sets `ovr_err`.
- Clear-and-set collision: if a vector is accepted in the apply cycle, its mask bit set wins over the clear. This cannot occur while `rx_rdy` gating holds, but it is implemented for robustness.

## Timing

- Reset values (at the first `clk_i` edge with `rst_n_i = 0`):
  - state IDLE.
  - All `wen*_o`, `i_data*_o`, `tx_vld`, `tx_vec`, `stg`, `rcv_mask`, `clk_0_h_d`, `edge_q`, watchdog: 0.
  - `wd_err`, `ovr_err`: 0.
  - `freeze_clk` 0; `rx_rdy` 0 while reset is low.
- Reset mid-operation discards staged vectors and any pending reply.
- `clk_0_h` low→high sampled at edge k gives `edge_q = 1` after edge k. The FSM enters WAIT_VEC after edge k+1, and `freeze_clk` rises then.
- If the mask is already full on entering WAIT_VEC: outputs update and `tx_vld` rises after edge k+2. Minimum edge-to-reply latency is 2 `clk_i` cycles after `edge_q`.
- `tx_vec` is stable from capture until the handshake completes. `tx_vld` drops the cycle after acceptance, and `freeze_clk` falls in the same cycle.
- Outputs `wen*_o` / `i_data*_o` hold until the next apply. The strobes are levels per mission cycle, not one-cycle pulses.

## Configuration

- `PART_2_TGT_WATCHDOG_EN`:
  - Defined: the watchdog counter (32-bit) and the ERROR state are implemented.
  - Undefined: WAIT_VEC waits indefinitely, ERROR is unreachable, and `wd_err` is tied to 0. `WATCHDOG_MAX` is unused.

## Test plan

- Basic exchange:
  - Stimulus: pre-load slots 0, 1, 2 with `0x1A5`, `0x03C`, `0x000`; set `valid_i = 1`, `o_data_i = 0x7E`; apply a `clk_0_h` edge.
  - Response: `wen0_o = 1`, `i_data0_o = 0xA5`, `i_data1_o = 0x3C`; `tx_vec = 0x17E`; `tx_vld` asserted 2 cycles after `edge_q`.
- Late vectors:
  - Stimulus: edge first, slot 2 delivered 50 cycles later.
  - Response: `freeze_clk = 1` for the 50-cycle wait, outputs unchanged until the apply, `tx_vld` 1 cycle after the mask is full.
- Backpressure and duplicates:
  - Stimulus: `tx_rdy = 0` for 20 cycles; slot 0 sent twice with `0x101` then `0x102`.
  - Response: `tx_vec` is held stable, `i_data0_o = 0x02`, and `rx_rdy = 0` once the mask is full.
- Watchdog (macro defined, `WATCHDOG_MAX = 16`):
  - Stimulus: edge with only slot 0 delivered.
  - Response: `wd_err = 1` after 17 WAIT_VEC cycles; `freeze_clk` stays 1 and `rx_rdy = 0`.
- Overrun and reset:
  - Stimulus: a second edge in SEND, then `rst_n_i` low for 1 cycle during WAIT_VEC.
  - Response: `ovr_err = 1`; after reset, all outputs 0, `ovr_err = 0`, and the mask is cleared.

Source files
------------

// File: rtl/part_2_target_fringe.sv
// Target-side partition fringe: stages three exported vectors, applies them on each
// mission-clock edge and returns the local reply. Optional watchdog: PART_2_TGT_WATCHDOG_EN.
module part_2_target_fringe #(
  parameter int N            = 9,
  parameter int WATCHDOG_MAX = 10000
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clk_0_h,
  output logic         freeze_clk,
  input  logic         rx_vld,
  input  logic [1:0]   rx_idx,
  input  logic [N-1:0] rx_vec,
  output logic         rx_rdy,
  output logic         tx_vld,
  output logic [N-1:0] tx_vec,
  input  logic         tx_rdy,
  input  logic         valid_i,
  input  logic [7:0]   o_data_i,
  output logic         wen0_o,
  output logic         wen1_o,
  output logic         wen2_o,
  output logic [7:0]   i_data0_o,
  output logic [7:0]   i_data1_o,
  output logic [7:0]   i_data2_o,
  output logic         wd_err,
  output logic         ovr_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_VEC = 2'd1;
  localparam logic [1:0] SEND     = 2'd2;
  localparam logic [1:0] ERROR    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                clk0_d_q;
  logic                edge_q;
  logic [2:0][N-1:0]   stg_q, stg_d;
  logic [2:0][N-1:0]   app_q, app_d;
  logic [2:0]          mask_q, mask_d;
  logic                tx_vld_q, tx_vld_d;
  logic [N-1:0]        tx_vec_q, tx_vec_d;
  logic                ovr_q, ovr_d;
  logic                acc;

`ifdef PART_2_TGT_WATCHDOG_EN
  logic [31:0]         wd_q, wd_d;
`endif

  assign rx_rdy = rst_n_i
                & ((state_q == IDLE) | (state_q == WAIT_VEC))
                & (mask_q != 3'b111);
  assign acc    = rx_vld & rx_rdy;

  assign freeze_clk = (state_q != IDLE);
  assign tx_vld     = tx_vld_q;
  assign tx_vec     = tx_vec_q;
  assign ovr_err    = ovr_q;

  assign wen0_o    = app_q[0][8];
  assign wen1_o    = app_q[1][8];
  assign wen2_o    = app_q[2][8];
  assign i_data0_o = app_q[0][7:0];
  assign i_data1_o = app_q[1][7:0];
  assign i_data2_o = app_q[2][7:0];

`ifdef PART_2_TGT_WATCHDOG_EN
  assign wd_err = (state_q == ERROR);
`else
  // No watchdog: the limit only matters when negative, which never happens.
  assign wd_err = (WATCHDOG_MAX < 0);
`endif

  // Next-state for FSM, staging, applied outputs, reply and error flags.
  always_comb begin
    state_d  = state_q;
    stg_d    = stg_q;
    app_d    = app_q;
    mask_d   = mask_q;
    tx_vld_d = tx_vld_q;
    tx_vec_d = tx_vec_q;
    ovr_d    = ovr_q;
`ifdef PART_2_TGT_WATCHDOG_EN
    wd_d     = wd_q;
`endif
    if (edge_q && (state_q != IDLE)) ovr_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (edge_q) begin
          tx_vec_d = {valid_i, o_data_i};
          state_d  = WAIT_VEC;
`ifdef PART_2_TGT_WATCHDOG_EN
          wd_d     = '0;
`endif
        end
      end
      WAIT_VEC: begin
        if (mask_q == 3'b111) begin
          app_d    = stg_q;
          mask_d   = '0;
          tx_vld_d = 1'b1;
          state_d  = SEND;
        end else begin
`ifdef PART_2_TGT_WATCHDOG_EN
          if (wd_q >= 32'(WATCHDOG_MAX)) state_d = ERROR;
          else wd_d = wd_q + 32'd1;
`endif
        end
      end
      SEND: begin
        if (tx_vld_q && tx_rdy) begin
          tx_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
    // A slot write is applied last so its mask bit wins over the clear.
    if (acc && (rx_idx != 2'd3)) begin
      stg_d[rx_idx]  = rx_vec;
      mask_d[rx_idx] = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      clk0_d_q <= 1'b0;
      edge_q   <= 1'b0;
      stg_q    <= '0;
      app_q    <= '0;
      mask_q   <= '0;
      tx_vld_q <= 1'b0;
      tx_vec_q <= '0;
      ovr_q    <= 1'b0;
`ifdef PART_2_TGT_WATCHDOG_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      clk0_d_q <= clk_0_h;
      edge_q   <= clk_0_h & ~clk0_d_q;
      stg_q    <= stg_d;
      app_q    <= app_d;
      mask_q   <= mask_d;
      tx_vld_q <= tx_vld_d;
      tx_vec_q <= tx_vec_d;
      ovr_q    <= ovr_d;
`ifdef PART_2_TGT_WATCHDOG_EN
      wd_q     <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_part_2_target_fringe.sv
// Directed bench for part_2_target_fringe.
// Watchdog steps follow PART_2_TGT_WATCHDOG_EN.
module tb_part_2_target_fringe;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       clk_0_h = 1'b0;
  logic       freeze_clk;
  logic       rx_vld = 1'b0;
  logic [1:0] rx_idx = 2'd0;
  logic [8:0] rx_vec = 9'd0;
  logic       rx_rdy;
  logic       tx_vld;
  logic [8:0] tx_vec;
  logic       tx_rdy = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] o_data_i = 8'd0;
  logic       wen0_o, wen1_o, wen2_o;
  logic [7:0] i_data0_o, i_data1_o, i_data2_o;
  logic       wd_err, ovr_err;

  int vecs = 0;
  int errs = 0;

`ifdef PART_2_TGT_WATCHDOG_EN
  localparam int LATE = 10;
`else
  localparam int LATE = 50;
`endif

  part_2_target_fringe #(.N(9), .WATCHDOG_MAX(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_0_h(clk_0_h),
    .freeze_clk(freeze_clk),
    .rx_vld(rx_vld), .rx_idx(rx_idx), .rx_vec(rx_vec), .rx_rdy(rx_rdy),
    .tx_vld(tx_vld), .tx_vec(tx_vec), .tx_rdy(tx_rdy),
    .valid_i(valid_i), .o_data_i(o_data_i),
    .wen0_o(wen0_o), .wen1_o(wen1_o), .wen2_o(wen2_o),
    .i_data0_o(i_data0_o), .i_data1_o(i_data1_o), .i_data2_o(i_data2_o),
    .wd_err(wd_err), .ovr_err(ovr_err)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] idx, input logic [8:0] v);
    int n;
    n = 0;
    rx_vld = 1'b1;
    rx_idx = idx;
    rx_vec = v;
    while (!rx_rdy && n < 50) begin
      tick();
      n++;
    end
    chk("send_rdy", 32'(rx_rdy), 32'h1);
    tick();
    rx_vld = 1'b0;
  endtask

  task automatic medge();
    clk_0_h = 1'b1;
    tick();
    clk_0_h = 1'b0;
  endtask

  initial begin
    logic bad;
    // reset
    tick();
    tick();
    chk("rst_freeze", 32'(freeze_clk), 32'h0);
    chk("rst_rx_rdy", 32'(rx_rdy), 32'h0);
    chk("rst_tx_vld", 32'(tx_vld), 32'h0);
    chk("rst_tx_vec", 32'(tx_vec), 32'h0);
    chk("rst_wen0", 32'(wen0_o), 32'h0);
    chk("rst_data0", 32'(i_data0_o), 32'h0);
    chk("rst_wd", 32'(wd_err), 32'h0);
    chk("rst_ovr", 32'(ovr_err), 32'h0);
    rst_n_i = 1'b1;
    tick();
    chk("idle_rx_rdy", 32'(rx_rdy), 32'h1);

    // basic exchange with pre-loaded slots
    send(2'd0, 9'h1A5);
    send(2'd1, 9'h03C);
    send(2'd2, 9'h000);
    chk("full_rx_rdy", 32'(rx_rdy), 32'h0);
    valid_i  = 1'b1;
    o_data_i = 8'h7E;
    medge();
    chk("b_freeze_k", 32'(freeze_clk), 32'h0);
    tick();
    chk("b_freeze_k1", 32'(freeze_clk), 32'h1);
    chk("b_txvld_k1", 32'(tx_vld), 32'h0);
    chk("b_txvec_k1", 32'(tx_vec), 32'h17E);
    valid_i  = 1'b0;
    o_data_i = 8'h00;
    tick();
    chk("b_txvld", 32'(tx_vld), 32'h1);
    chk("b_wen0", 32'(wen0_o), 32'h1);
    chk("b_data0", 32'(i_data0_o), 32'hA5);
    chk("b_wen1", 32'(wen1_o), 32'h0);
    chk("b_data1", 32'(i_data1_o), 32'h3C);
    chk("b_wen2", 32'(wen2_o), 32'h0);
    chk("b_data2", 32'(i_data2_o), 32'h00);
    chk("b_txvec", 32'(tx_vec), 32'h17E);
    chk("b_rxrdy_send", 32'(rx_rdy), 32'h0);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    chk("b_txvld_done", 32'(tx_vld), 32'h0);
    chk("b_freeze_done", 32'(freeze_clk), 32'h0);
    chk("b_rxrdy_idle", 32'(rx_rdy), 32'h1);

    // late vectors: slot 2 arrives while waiting
    send(2'd0, 9'h111);
    send(2'd1, 9'h122);
    o_data_i = 8'h55;
    medge();
    tick();
    bad = 1'b0;
    for (int i = 0; i < LATE; i++) begin
      tick();
      if (freeze_clk !== 1'b1 || i_data0_o !== 8'hA5 ||
          tx_vld !== 1'b0) bad = 1'b1;
    end
    chk("l_wait_hold", 32'(bad), 32'h0);
    send(2'd2, 9'h1C3);
    chk("l_txvld_full", 32'(tx_vld), 32'h0);
    tick();
    chk("l_txvld", 32'(tx_vld), 32'h1);
    chk("l_wen0", 32'(wen0_o), 32'h1);
    chk("l_data0", 32'(i_data0_o), 32'h11);
    chk("l_wen1", 32'(wen1_o), 32'h1);
    chk("l_data1", 32'(i_data1_o), 32'h22);
    chk("l_wen2", 32'(wen2_o), 32'h1);
    chk("l_data2", 32'(i_data2_o), 32'hC3);
    chk("l_txvec", 32'(tx_vec), 32'h055);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;

    // backpressure, duplicate slot, overrun edge in SEND
    send(2'd0, 9'h101);
    send(2'd0, 9'h102);
    chk("d_rxrdy_dup", 32'(rx_rdy), 32'h1);
    send(2'd1, 9'h000);
    send(2'd2, 9'h000);
    chk("d_rxrdy_full", 32'(rx_rdy), 32'h0);
    valid_i  = 1'b1;
    o_data_i = 8'h81;
    medge();
    tick();
    tick();
    chk("d_txvld", 32'(tx_vld), 32'h1);
    chk("d_data0", 32'(i_data0_o), 32'h02);
    chk("d_wen0", 32'(wen0_o), 32'h1);
    chk("d_wen1", 32'(wen1_o), 32'h0);
    valid_i  = 1'b0;
    o_data_i = 8'h00;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_vec !== 9'h181 || tx_vld !== 1'b1) bad = 1'b1;
    end
    chk("d_txvec_hold", 32'(bad), 32'h0);
    medge();
    chk("o_ovr_before", 32'(ovr_err), 32'h0);
    tick();
    chk("o_ovr", 32'(ovr_err), 32'h1);
    chk("o_txvld", 32'(tx_vld), 32'h1);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    chk("o_txvld_done", 32'(tx_vld), 32'h0);
    chk("o_freeze_done", 32'(freeze_clk), 32'h0);

    // discarded slot 3, then incomplete exchange
    send(2'd3, 9'h1FF);
    chk("x_idx3_rdy", 32'(rx_rdy), 32'h1);
    send(2'd0, 9'h1EE);
    medge();
    tick();
    chk("w_freeze", 32'(freeze_clk), 32'h1);
`ifdef PART_2_TGT_WATCHDOG_EN
    repeat (16) tick();
    chk("w_wd_before", 32'(wd_err), 32'h0);
    tick();
    chk("w_wd", 32'(wd_err), 32'h1);
    chk("w_freeze_err", 32'(freeze_clk), 32'h1);
    chk("w_rxrdy_err", 32'(rx_rdy), 32'h0);
`else
    repeat (30) tick();
    chk("w_wd_off", 32'(wd_err), 32'h0);
    chk("w_freeze_wait", 32'(freeze_clk), 32'h1);
    chk("w_txvld_wait", 32'(tx_vld), 32'h0);
    chk("w_rxrdy_wait", 32'(rx_rdy), 32'h1);
`endif

    // one-cycle reset mid-operation
    rst_n_i = 1'b0;
    #1;
    chk("r_rxrdy_low", 32'(rx_rdy), 32'h0);
    tick();
    rst_n_i = 1'b1;
    chk("r_freeze", 32'(freeze_clk), 32'h0);
    chk("r_txvld", 32'(tx_vld), 32'h0);
    chk("r_txvec", 32'(tx_vec), 32'h0);
    chk("r_out0", 32'({wen0_o, i_data0_o}), 32'h0);
    chk("r_out1", 32'({wen1_o, i_data1_o}), 32'h0);
    chk("r_out2", 32'({wen2_o, i_data2_o}), 32'h0);
    chk("r_ovr", 32'(ovr_err), 32'h0);
    chk("r_wd", 32'(wd_err), 32'h0);
    send(2'd1, 9'h1AB);
    send(2'd2, 9'h1CD);
    chk("r_mask_clear", 32'(rx_rdy), 32'h1);
    valid_i  = 1'b1;
    o_data_i = 8'h42;
    medge();
    tick();
    repeat (3) tick();
    chk("r_txvld_wait", 32'(tx_vld), 32'h0);
    send(2'd0, 9'h10F);
    tick();
    chk("r_txvld", 32'(tx_vld), 32'h1);
    chk("r_apply0", 32'({wen0_o, i_data0_o}), 32'h10F);
    chk("r_apply1", 32'({wen1_o, i_data1_o}), 32'h1AB);
    chk("r_apply2", 32'({wen2_o, i_data2_o}), 32'h1CD);
    chk("r_txvec2", 32'(tx_vec), 32'h142);
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
    chk("r_done", 32'(tx_vld), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
